watch_set_ctrl: RTL and testbench

Time-setting controller for the watch: accepts debounced button pulses and UART command bytes, arbitrates them into one action per cycle, runs a mode FSM (normal / edit hour / edit min / edit sec), and emits single-cycle increment strobes to the watch datapath's `i_run_hour/min/sec` inputs. It also drives a blink enable for the display of the field being edited. It sits between the button debouncers / UART RX and `watch_dp`, replacing the direct button-to-datapath path.

---
 rtl/watch_pkg.sv | 52 +++++
 rtl/watch_edit_timer.sv | 44 ++++
 rtl/watch_set_ctrl.sv | 108 ++++++++++
 tb/tb_watch_set_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared definitions for the watch time-setting path: mode encoding, UART
// command bytes, decoded command set and default timer lengths.
package watch_pkg;

   typedef enum logic [1:0] {
      MODE_WATCH     = 2'd0,
      MODE_EDIT_HOUR = 2'd1,
      MODE_EDIT_MIN  = 2'd2,
      MODE_EDIT_SEC  = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_MODE,
      CMD_INC,
      CMD_QUIT,
      CMD_HOUR,
      CMD_MIN,
      CMD_SEC,
      CMD_ERR
   } cmd_t;

   localparam logic [7:0] BYTE_MODE = 8'h4D;  // 'M'
   localparam logic [7:0] BYTE_INC  = 8'h55;  // 'U'
   localparam logic [7:0] BYTE_QUIT = 8'h51;  // 'Q'
   localparam logic [7:0] BYTE_HOUR = 8'h68;  // 'h'
   localparam logic [7:0] BYTE_MIN  = 8'h6D;  // 'm'
   localparam logic [7:0] BYTE_SEC  = 8'h73;  // 's'

   localparam int unsigned BLINK_CYC_DEF   = 50_000_000;
   localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000_000;

   function automatic cmd_t decode_byte(input logic [7:0] b);
      cmd_t c;
      case (b)
         BYTE_MODE: c = CMD_MODE;
         BYTE_INC:  c = CMD_INC;
         BYTE_QUIT: c = CMD_QUIT;
         BYTE_HOUR: c = CMD_HOUR;
         BYTE_MIN:  c = CMD_MIN;
         BYTE_SEC:  c = CMD_SEC;
         default:   c = CMD_ERR;
      endcase
      return c;
   endfunction

   // MODE cycles through all four states, so a 2-bit wrap is exactly right.
   function automatic mode_t mode_advance(input mode_t m);
      return mode_t'(m + 2'd1);
   endfunction

endpackage

// File: rtl/watch_edit_timer.sv
// Blink and idle-timeout counters for the edit modes. Both restart on i_clear
// and sit at zero (blink held on) whenever i_enable is low.
module watch_edit_timer #(
   parameter int unsigned BLINK_CYC   = 50_000_000,
   parameter int unsigned TIMEOUT_CYC = 1_000_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_blink,
   output logic o_timeout
);

   localparam int BW = (BLINK_CYC   > 1) ? $clog2(BLINK_CYC)   : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   logic [BW-1:0] r_blink_cnt;
   logic [TW-1:0] r_to_cnt;
   logic          r_blink;
   logic          w_blink_wrap;

   assign w_blink_wrap = (r_blink_cnt == BW'(BLINK_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_blink_cnt <= '0;
         r_to_cnt    <= '0;
         r_blink     <= 1'b1;
      end else if (i_clear || !i_enable) begin
         r_blink_cnt <= '0;
         r_to_cnt    <= '0;
         r_blink     <= 1'b1;
      end else begin
         r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
         r_blink     <= w_blink_wrap ? ~r_blink : r_blink;
         r_to_cnt    <= r_to_cnt + 1'b1;
      end
   end

   assign o_blink   = r_blink;
   assign o_timeout = (r_to_cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/watch_set_ctrl.sv
// Time-setting controller: arbitrates button pulses and UART bytes into one
// command per cycle, runs the edit-mode FSM and emits registered strobes.
module watch_set_ctrl
   import watch_pkg::*;
#(
   parameter int unsigned BLINK_CYC   = BLINK_CYC_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_l,
   input  logic       i_btn_u,
   input  logic       i_btn_d,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic       o_rx_ready,
   output logic       o_run_hour,
   output logic       o_run_min,
   output logic       o_run_sec,
   output logic [1:0] o_mode,
   output logic       o_blink,
   output logic       o_cmd_err
);

   mode_t r_mode, w_mode_next;
   cmd_t  w_cmd;
   logic  r_run_hour, r_run_min, r_run_sec, r_cmd_err;
   logic  w_run_hour_next, w_run_min_next, w_run_sec_next, w_cmd_err_next;
   logic  w_rx_ready, w_timeout, w_blink;

   // A byte is only refused in a button cycle or while reset is held.
   assign w_rx_ready = rst & ~(i_btn_l | i_btn_u | i_btn_d);

   always_comb begin
      w_cmd = CMD_NONE;
      if (i_btn_d)
         w_cmd = CMD_QUIT;
      else if (i_btn_l)
         w_cmd = CMD_MODE;
      else if (i_btn_u)
         w_cmd = CMD_INC;
      else if (i_rx_valid && w_rx_ready)
         w_cmd = decode_byte(i_rx_data);
   end

   always_comb begin
      w_mode_next     = r_mode;
      w_run_hour_next = 1'b0;
      w_run_min_next  = 1'b0;
      w_run_sec_next  = 1'b0;
      w_cmd_err_next  = 1'b0;
      case (w_cmd)
         CMD_MODE: w_mode_next = mode_advance(r_mode);
         CMD_QUIT: w_mode_next = MODE_WATCH;
         CMD_INC: begin
            w_run_hour_next = (r_mode == MODE_EDIT_HOUR);
            w_run_min_next  = (r_mode == MODE_EDIT_MIN);
            w_run_sec_next  = (r_mode == MODE_EDIT_SEC);
         end
         CMD_HOUR: w_run_hour_next = 1'b1;
         CMD_MIN:  w_run_min_next  = 1'b1;
         CMD_SEC:  w_run_sec_next  = 1'b1;
         CMD_ERR:  w_cmd_err_next  = 1'b1;
         default: begin
            // Timeout only acts on an idle cycle; any command takes precedence.
            if (w_timeout && (r_mode != MODE_WATCH))
               w_mode_next = MODE_WATCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mode     <= MODE_WATCH;
         r_run_hour <= 1'b0;
         r_run_min  <= 1'b0;
         r_run_sec  <= 1'b0;
         r_cmd_err  <= 1'b0;
      end else begin
         r_mode     <= w_mode_next;
         r_run_hour <= w_run_hour_next;
         r_run_min  <= w_run_min_next;
         r_run_sec  <= w_run_sec_next;
         r_cmd_err  <= w_cmd_err_next;
      end
   end

   watch_edit_timer #(
      .BLINK_CYC   (BLINK_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_cmd != CMD_NONE),
      .i_enable  (w_mode_next != MODE_WATCH),
      .o_blink   (w_blink),
      .o_timeout (w_timeout)
   );

   assign o_rx_ready = w_rx_ready;
   assign o_run_hour = r_run_hour;
   assign o_run_min  = r_run_min;
   assign o_run_sec  = r_run_sec;
   assign o_mode     = r_mode;
   assign o_blink    = w_blink;
   assign o_cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Randomised and directed bench for watch_set_ctrl against a cycle-count
// reference model (mode number plus idle-cycle count since last command).
module tb_watch_set_ctrl;

   localparam int B = 4;
   localparam int T = 20;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       o_rx_ready, o_run_hour, o_run_min, o_run_sec, o_blink, o_cmd_err;
   logic [1:0] o_mode;

   int n_tests = 0;
   int n_fail  = 0;

   int m_mode = 0;
   int m_idle = 0;
   int e_h = 0, e_m = 0, e_s = 0, e_err = 0;

   watch_set_ctrl #(.BLINK_CYC(B), .TIMEOUT_CYC(T)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_btn_l    (btn_l),
      .i_btn_u    (btn_u),
      .i_btn_d    (btn_d),
      .i_rx_data  (rx_data),
      .i_rx_valid (rx_valid),
      .o_rx_ready (o_rx_ready),
      .o_run_hour (o_run_hour),
      .o_run_min  (o_run_min),
      .o_run_sec  (o_run_sec),
      .o_mode     (o_mode),
      .o_blink    (o_blink),
      .o_cmd_err  (o_cmd_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_inc();
      if (m_mode == 1) e_h = 1;
      if (m_mode == 2) e_m = 1;
      if (m_mode == 3) e_s = 1;
   endtask

   task automatic post_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
   endtask

   task automatic check_outputs(input string tag);
      int exp_blink;
      exp_blink = (m_mode == 0) ? 1 : (((m_idle / B) % 2) == 0 ? 1 : 0);
      check_eq({tag, "_mode"},  int'(o_mode),     m_mode);
      check_eq({tag, "_hour"},  int'(o_run_hour), e_h);
      check_eq({tag, "_min"},   int'(o_run_min),  e_m);
      check_eq({tag, "_sec"},   int'(o_run_sec),  e_s);
      check_eq({tag, "_err"},   int'(o_cmd_err),  e_err);
      check_eq({tag, "_blink"}, int'(o_blink),    exp_blink);
   endtask

   // One clock: drive buttons, check ready, advance model, check outputs.
   task automatic step(input logic l, input logic u, input logic d);
      bit acc;
      bit taken;
      btn_l = l; btn_u = u; btn_d = d;
      #1;
      check_eq("rx_ready", int'(o_rx_ready), (l | u | d) ? 0 : 1);
      e_h = 0; e_m = 0; e_s = 0; e_err = 0;
      acc = 1'b1;
      taken = 1'b0;
      if (d)
         m_mode = 0;
      else if (l)
         m_mode = (m_mode + 1) % 4;
      else if (u)
         model_inc();
      else if (rx_valid) begin
         taken = 1'b1;
         case (rx_data)
            8'h4D: m_mode = (m_mode + 1) % 4;
            8'h55: model_inc();
            8'h51: m_mode = 0;
            8'h68: e_h = 1;
            8'h6D: e_m = 1;
            8'h73: e_s = 1;
            default: e_err = 1;
         endcase
      end else
         acc = 1'b0;
      if (acc)
         m_idle = 0;
      else if (m_mode != 0) begin
         if (m_idle == T - 1) m_mode = 0;
         else m_idle++;
      end
      if (m_mode == 0) m_idle = 0;
      @(posedge clk);
      #1;
      btn_l = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
      if (taken) rx_valid = 1'b0;
      check_outputs("step");
   endtask

   logic [7:0] byte_tab [8];

   initial begin
      int p;
      byte_tab = '{8'h4D, 8'h55, 8'h51, 8'h68, 8'h6D, 8'h73, 8'h41, 8'h00};

      // Reset state, with a byte offered to confirm it is refused.
      post_byte(8'h68);
      #12;
      check_eq("rst_ready", int'(o_rx_ready), 0);
      check_outputs("rst");
      rx_valid = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      // MODE x3 at 10-cycle spacing, then a 4th back to WATCH.
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 0);
         check_eq("mode_seq", int'(o_mode), k + 1);
         repeat (9) step(0, 0, 0);
      end
      step(1, 0, 0);
      check_eq("mode_wrap", int'(o_mode), 0);

      // INC in EDIT_MIN, then INC in WATCH.
      step(1, 0, 0); step(1, 0, 0);
      step(0, 1, 0);
      check_eq("inc_min", int'(o_run_min), 1);
      step(0, 0, 1);
      step(0, 1, 0);
      check_eq("inc_watch", int'({o_run_hour, o_run_min, o_run_sec}), 0);

      // Held 's' stalled by btn_u in EDIT_HOUR.
      step(1, 0, 0);
      post_byte(8'h73);
      step(0, 1, 0);
      check_eq("stall_hour", int'(o_run_hour), 1);
      step(0, 0, 0);
      check_eq("stall_sec", int'(o_run_sec), 1);

      // Unknown byte, then 'Q' from EDIT_SEC.
      post_byte(8'h41);
      step(0, 0, 0);
      check_eq("bad_byte", int'(o_cmd_err), 1);
      step(1, 0, 0); step(1, 0, 0);
      post_byte(8'h51);
      step(0, 0, 0);
      check_eq("quit_byte", int'(o_mode), 0);

      // Blink/timeout: idle in EDIT_HOUR, INC at idle 10, then run out.
      step(1, 0, 0);
      repeat (10) step(0, 0, 0);
      step(0, 1, 0);
      repeat (19) step(0, 0, 0);
      check_eq("before_to", int'(o_mode), 1);
      step(0, 0, 0);
      check_eq("after_to", int'(o_mode), 0);

      // MODE+QUIT together in EDIT_MIN.
      step(1, 0, 0); step(1, 0, 0);
      step(1, 0, 1);
      check_eq("quit_prio", int'(o_mode), 0);

      // Random traffic in alternating dense and sparse phases.
      for (int i = 0; i < 3000; i++) begin
         logic l, u, d;
         p = ((i / 150) % 2 == 0) ? 30 : 2;
         l = ($urandom_range(0, 299) < p);
         u = ($urandom_range(0, 299) < p);
         d = ($urandom_range(0, 599) < p);
         if (!rx_valid && $urandom_range(0, 99) < p) begin
            int idx;
            idx = $urandom_range(0, 7);
            post_byte(idx == 7 ? 8'($urandom_range(0, 255)) : byte_tab[idx]);
         end
         step(l, u, d);
      end

      // Asynchronous reset mid-edit.
      rx_valid = 1'b0;
      step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
      post_byte(8'h68);
      #3 rst = 1'b0;
      #1;
      m_mode = 0; m_idle = 0;
      e_h = 0; e_m = 0; e_s = 0; e_err = 0;
      check_outputs("async_rst");
      check_eq("async_rst_ready", int'(o_rx_ready), 0);
      rx_valid = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      step(0, 1, 0);
      step(1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
